// File: rtl/z3_pkg.sv
// Shared types and constants for the Zorro III initiator: FSM state encoding,
// function codes and the fixed quick-interrupt acknowledge address/strobes.
package z3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        DATA,
        TERM,
        RECOVER
    } state_t;

    localparam logic [2:0] FC_SUPER_DATA = 3'b101;
    localparam logic [2:0] FC_CPU_SPACE  = 3'b111;

    // Longword address [31:2]: A[19:16] = 4'hF, A[3:2] = 2'b01, rest zero.
    localparam logic [29:0] QINT_ADDR = 30'h0003_C001;
    localparam logic [3:0]  QINT_DS_N = 4'hE;

endpackage

// File: rtl/z3_sync2.sv
// Two-flop synchroniser for an asynchronous active-low bus input; resets to
// the inactive (high) level so no spurious response is seen out of reset.
module z3_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/zorro3_initiator.sv
// Zorro III bus initiator: single read/write cycles with DTACK/SLAVE/BERR
// synchronisation, slave-presence check, timeout and BERR abort.
// Optional quick interrupt acknowledge cycles are enabled by Z3_QUICKINT_EN.
import z3_pkg::*;

module zorro3_initiator #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned SLAVE_WAIT  = 8
) (
    input  logic        clk,
    input  logic        IORST_n,
`ifdef Z3_QUICKINT_EN
    input  logic        qint_req,
`endif
    input  logic        req,
    input  logic        wr,
    input  logic [29:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [29:0] A,
    output logic [2:0]  FC,
    output logic        READ,
    output logic        Z_FCS_n,
    output logic [3:0]  DS_n,
    output logic        DOE,
    output logic        Z_LOCK,
    output logic        MTCR_n,
    output logic [31:0] D_out,
    output logic        D_oe,
    input  logic [31:0] D_in,
    input  logic        DTACK_n,
    input  logic        SLAVE_n,
    input  logic        BERR_n
);

    // cnt is cleared in STROBE and reads 0 on the edge DS_n asserts; the slave
    // window adds the two synchroniser stages plus that starting offset.
    localparam logic [8:0] TO_LIM    = 9'(TIMEOUT_CYC);
    localparam logic [8:0] SLAVE_LIM = 9'(SLAVE_WAIT + 3);

    logic dtack_q, slave_q, berr_q;
    logic dtack_s, slave_s, berr_s;

    z3_sync2 u_sync_dtack (.clk(clk), .rst_n(IORST_n), .d(DTACK_n), .q(dtack_q));
    z3_sync2 u_sync_slave (.clk(clk), .rst_n(IORST_n), .d(SLAVE_n), .q(slave_q));
    z3_sync2 u_sync_berr  (.clk(clk), .rst_n(IORST_n), .d(BERR_n),  .q(berr_q));

    assign dtack_s = ~dtack_q;
    assign slave_s = ~slave_q;
    assign berr_s  = ~berr_q;

    state_t      state;
    logic [8:0]  cnt;
    logic        wr_q, qint_q, qint_go;
    logic [3:0]  be_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic        fail, done;

`ifdef Z3_QUICKINT_EN
    logic [2:0] fc_q;
    logic       lock_q, mtcr_q;
    assign qint_go = qint_req;
    assign FC      = fc_q;
    assign Z_LOCK  = lock_q;
    assign MTCR_n  = mtcr_q;
`else
    assign qint_go = 1'b0;
    assign FC      = FC_SUPER_DATA;
    assign Z_LOCK  = 1'b1;
    assign MTCR_n  = 1'b1;
`endif

    // BERR beats DTACK; DTACK beats the slave check and the timeout.
    assign fail = berr_s || (!dtack_s && ((cnt == SLAVE_LIM && !slave_s) || cnt == TO_LIM));
    assign done = fail || dtack_s;

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            qint_q  <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            A       <= '0;
            READ    <= 1'b1;
            Z_FCS_n <= 1'b1;
            DS_n    <= '1;
            DOE     <= 1'b0;
            D_out   <= '0;
            D_oe    <= 1'b0;
`ifdef Z3_QUICKINT_EN
            fc_q    <= FC_SUPER_DATA;
            lock_q  <= 1'b1;
            mtcr_q  <= 1'b1;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (qint_go || req) begin
                        qint_q  <= qint_go;
                        wr_q    <= qint_go ? 1'b0 : wr;
                        be_q    <= qint_go ? ~QINT_DS_N : be;
                        addr_q  <= qint_go ? QINT_ADDR : addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    A     <= addr_q;
                    READ  <= ~wr_q;
`ifdef Z3_QUICKINT_EN
                    fc_q   <= qint_q ? FC_CPU_SPACE : FC_SUPER_DATA;
                    lock_q <= ~qint_q;
                    mtcr_q <= ~qint_q;
`endif
                    state <= STROBE;
                end
                STROBE: begin
                    Z_FCS_n <= 1'b0;
                    cnt     <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    DS_n  <= ~be_q;
                    DOE   <= 1'b1;
                    D_oe  <= wr_q;
                    D_out <= wdata_q;
                    cnt   <= cnt + 9'd1;
                    if (done) begin
                        Z_FCS_n <= 1'b1;
                        DS_n    <= '1;
                        DOE     <= 1'b0;
                        D_oe    <= 1'b0;
                        ack     <= 1'b1;
                        err     <= fail;
                        cnt     <= '0;
                        state   <= TERM;
`ifdef Z3_QUICKINT_EN
                        lock_q  <= 1'b1;
                        mtcr_q  <= 1'b1;
`endif
                        if (!fail && !wr_q)
                            rdata <= qint_q ? {24'h0, D_in[7:0]} : D_in;
                    end
                end
                TERM: begin
                    cnt   <= '0;
                    state <= RECOVER;
                end
                RECOVER: begin
                    if ((!dtack_s && !berr_s) || cnt == TO_LIM) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zorro3_initiator.sv
// Directed self-checking bench for zorro3_initiator (default build; the
// quick-interrupt scenario is compiled when Z3_QUICKINT_EN is defined).
module tb_zorro3_initiator;

    logic        clk = 1'b0;
    logic        IORST_n;
    logic        req, wr;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        busy, ack, err;
    logic [31:0] rdata;
    logic [29:0] A;
    logic [2:0]  FC;
    logic        READ, Z_FCS_n, DOE, Z_LOCK, MTCR_n, D_oe;
    logic [3:0]  DS_n;
    logic [31:0] D_out, D_in;
    logic        DTACK_n, SLAVE_n, BERR_n;
`ifdef Z3_QUICKINT_EN
    logic        qint_req;
`endif

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    zorro3_initiator dut (
        .clk(clk), .IORST_n(IORST_n),
`ifdef Z3_QUICKINT_EN
        .qint_req(qint_req),
`endif
        .req(req), .wr(wr), .addr(addr), .be(be), .wdata(wdata),
        .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .A(A), .FC(FC), .READ(READ), .Z_FCS_n(Z_FCS_n), .DS_n(DS_n), .DOE(DOE),
        .Z_LOCK(Z_LOCK), .MTCR_n(MTCR_n), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .DTACK_n(DTACK_n), .SLAVE_n(SLAVE_n), .BERR_n(BERR_n)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a request; returns #1 after the accepting edge (edge 0).
    task automatic start_cycle(input logic w, input logic [29:0] a, input logic [3:0] b,
                               input logic [31:0] wd);
        req = 1'b1; wr = w; addr = a; be = b; wdata = wd;
        step();
        req = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic release_bus();
        DTACK_n = 1'b1; SLAVE_n = 1'b1; BERR_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, ack, err, READ, Z_FCS_n, DOE, Z_LOCK, MTCR_n, D_oe} !== 9'b000110110) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b",
                     {busy, ack, err, READ, Z_FCS_n, DOE, Z_LOCK, MTCR_n, D_oe}, 9'b000110110);
        end
        checks++;
        if ({rdata, A, D_out} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata %h A %h D_out %h expected all 0", rdata, A, D_out);
        end
        checks++;
        if ({FC, DS_n} !== 7'b101_1111) begin
            errors++;
            $display("FAIL reset_fc_ds: got FC %b DS_n %h expected 101 f", FC, DS_n);
        end
    endtask

    task automatic test_read();
        bit ok;
        start_cycle(1'b0, 30'h003A_0000, 4'hF, 32'h0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b expected 1", busy); end
        step(); // edge 1
        checks++;
        if ({A, READ, FC} !== {30'h003A_0000, 1'b1, 3'b101}) begin
            errors++; $display("FAIL read_addr: got A %h READ %b FC %b expected 3a0000 1 101", A, READ, FC);
        end
        step(); // edge 2
        checks++;
        if ({Z_FCS_n, DS_n} !== 5'b0_1111) begin
            errors++; $display("FAIL read_fcs: got FCS %b DS %h expected 0 f", Z_FCS_n, DS_n);
        end
        SLAVE_n = 1'b0;
        step(); // edge 3
        checks++;
        if ({DS_n, DOE, D_oe} !== 6'b0000_1_0) begin
            errors++; $display("FAIL read_ds: got DS %h DOE %b D_oe %b expected 0 1 0", DS_n, DOE, D_oe);
        end
        DTACK_n = 1'b0; D_in = 32'hDEAD_BEEF;
        req = 1'b1; wr = 1'b1; addr = 30'h0000_0042; // ignored while busy
        step(); // edge 4
        req = 1'b0;
        step(); // edge 5
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL read_early_ack: got %b expected 0", ack); end
        step(); // edge 6
        checks++;
        if ({ack, err, rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL read_ack: got ack %b err %b rdata %h expected 1 0 deadbeef", ack, err, rdata);
        end
        checks++;
        if ({Z_FCS_n, DS_n, DOE} !== 6'b1_1111_0) begin
            errors++; $display("FAIL read_term: got FCS %b DS %h DOE %b expected 1 f 0", Z_FCS_n, DS_n, DOE);
        end
        release_bus();
        step(); // edge 7
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %b expected 0", ack); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_idle: busy %b expected 0 within bound", busy); end
        repeat (3) step();
        checks++;
        if ({busy, Z_FCS_n} !== 2'b01) begin
            errors++; $display("FAIL busy_req_queued: got busy %b FCS %b expected 0 1", busy, Z_FCS_n);
        end
    endtask

    task automatic test_write();
        bit ok;
        start_cycle(1'b1, 30'h0000_0100, 4'h1, 32'h1234_5678);
        step();
        checks++;
        if (READ !== 1'b0) begin errors++; $display("FAIL write_read: got %b expected 0", READ); end
        step(); SLAVE_n = 1'b0;
        step(); // edge 3, DATA
        checks++;
        if ({DS_n, D_oe, DOE, D_out} !== {4'hE, 1'b1, 1'b1, 32'h1234_5678}) begin
            errors++; $display("FAIL write_data: got DS %h D_oe %b DOE %b D_out %h expected e 1 1 12345678",
                               DS_n, D_oe, DOE, D_out);
        end
        DTACK_n = 1'b0; D_in = 32'hAAAA_5555;
        repeat (3) step(); // edge 6
        checks++;
        if ({ack, err, rdata, D_oe} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL write_ack: got ack %b err %b rdata %h D_oe %b expected 1 0 deadbeef 0",
                               ack, err, rdata, D_oe);
        end
        release_bus();
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_idle: busy %b expected 0 within bound", busy); end
    endtask

    task automatic test_no_slave();
        bit ok;
        bit early;
        start_cycle(1'b0, 30'h0000_0200, 4'hF, 32'h0);
        repeat (3) step(); // edge 3: DS_n asserted
        checks++;
        if (DS_n !== 4'h0) begin errors++; $display("FAIL noslave_ds: got %h expected 0", DS_n); end
        early = 1'b0;
        for (int i = 4; i <= 13; i++) begin
            step();
            if (ack !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL noslave_early: ack seen before edge 14, expected none"); end
        step(); // edge 14 = DS_n edge + SLAVE_WAIT + 3
        checks++;
        if ({ack, err, rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL noslave_abort: got ack %b err %b rdata %h expected 1 1 deadbeef", ack, err, rdata);
        end
        checks++;
        if ({Z_FCS_n, DS_n, DOE, D_oe} !== 7'b1_1111_0_0) begin
            errors++; $display("FAIL noslave_strobes: got FCS %b DS %h DOE %b D_oe %b expected 1 f 0 0",
                               Z_FCS_n, DS_n, DOE, D_oe);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL noslave_idle: busy %b expected 0 within bound", busy); end
    endtask

    task automatic test_berr_dtack();
        bit ok;
        start_cycle(1'b0, 30'h0000_0300, 4'hF, 32'h0);
        step(); step(); SLAVE_n = 1'b0;
        step();
        DTACK_n = 1'b0; BERR_n = 1'b0; D_in = 32'h1111_2222;
        repeat (3) step(); // edge 6
        checks++;
        if ({ack, err, rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL berr_dtack: got ack %b err %b rdata %h expected 1 1 deadbeef", ack, err, rdata);
        end
        release_bus();
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL berr_idle: busy %b expected 0 within bound", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_cycle(1'b0, 30'h0000_0400, 4'hF, 32'h0);
        step(); step(); SLAVE_n = 1'b0;
        step(); // edge 3, DATA
        #5 IORST_n = 1'b0;
        #1;
        checks++;
        if ({Z_FCS_n, DS_n, busy} !== 6'b1_1111_0) begin
            errors++; $display("FAIL reset_mid: got FCS %b DS %h busy %b expected 1 f 0", Z_FCS_n, DS_n, busy);
        end
        release_bus();
        #5 IORST_n = 1'b1;
        step();
        start_cycle(1'b0, 30'h0000_0500, 4'hF, 32'h0);
        step(); step(); SLAVE_n = 1'b0;
        step();
        DTACK_n = 1'b0; D_in = 32'hCAFE_F00D;
        repeat (3) step();
        checks++;
        if ({ack, err, rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL reset_next: got ack %b err %b rdata %h expected 1 0 cafef00d", ack, err, rdata);
        end
        release_bus();
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_next_idle: busy %b expected 0 within bound", busy); end
    endtask

`ifdef Z3_QUICKINT_EN
    task automatic test_quickint();
        bit ok;
        qint_req = 1'b1;
        start_cycle(1'b1, 30'h0000_0600, 4'hF, 32'h0);
        qint_req = 1'b0;
        step(); // edge 1
        checks++;
        if ({FC, A, READ} !== {3'b111, 30'h0003_C001, 1'b1}) begin
            errors++; $display("FAIL qint_addr: got FC %b A %h READ %b expected 111 0003c001 1", FC, A, READ);
        end
        step(); SLAVE_n = 1'b0;
        checks++;
        if ({MTCR_n, Z_LOCK} !== 2'b00) begin
            errors++; $display("FAIL qint_mtcr: got MTCR %b LOCK %b expected 0 0", MTCR_n, Z_LOCK);
        end
        step();
        checks++;
        if (DS_n !== 4'hE) begin errors++; $display("FAIL qint_ds: got %h expected e", DS_n); end
        DTACK_n = 1'b0; D_in = 32'hFFFF_FF68;
        repeat (3) step();
        checks++;
        if ({ack, err, rdata, MTCR_n} !== {1'b1, 1'b0, 32'h0000_0068, 1'b1}) begin
            errors++; $display("FAIL qint_ack: got ack %b err %b rdata %h MTCR %b expected 1 0 00000068 1",
                               ack, err, rdata, MTCR_n);
        end
        release_bus();
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL qint_idle: busy %b expected 0 within bound", busy); end
    endtask
`endif

    initial begin
        IORST_n = 1'b0;
        req = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0; D_in = '0;
        release_bus();
`ifdef Z3_QUICKINT_EN
        qint_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 IORST_n = 1'b1;
        step();
        test_reset();
        test_read();
        test_write();
        test_no_slave();
        test_berr_dtack();
        test_reset_mid();
`ifdef Z3_QUICKINT_EN
        test_quickint();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
